// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the rate-1/2 Viterbi decoder: paces one ACS step per received
// symbol pair, traces back through survivor memory, then streams decoded bits in order.
module viterbi_frame_ctrl #(
    parameter int K         = 3,
    parameter int FRAME_LEN = 15,
    localparam int NS       = 2 ** (K - 1),
    localparam int SW       = $clog2(FRAME_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    sym_in,
    input  logic          sym_valid,
    output logic          sym_ready,
    output logic          acs_start,
    output logic          acs_init,
    output logic [1:0]    acs_sym,
    output logic [SW-1:0] acs_step,
    input  logic          acs_done,
    output logic [SW-1:0] surv_raddr,
    input  logic [NS-1:0] surv_rdata,
    output logic          dec_bit,
    output logic          dec_valid,
    input  logic          dec_ready,
    output logic          dec_last,
    output logic          busy
);

    localparam int ND = FRAME_LEN - (K - 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(FRAME_LEN - 1);
    localparam logic [SW-1:0] LAST_BIT  = SW'(ND - 1);

    typedef enum logic [2:0] {
        WAIT_SYM,
        ACS_RUN,
        TB_ADDR,
        TB_USE,
        OUT
    } state_t;

    state_t               state;
    logic [SW-1:0]        cnt;
    logic [SW-1:0]        tb;
    logic [SW-1:0]        oidx;
    logic [K-2:0]         s_reg;
    logic [FRAME_LEN-1:0] bitbuf;

    logic [SW-1:0]        oidx_nxt;
    logic                 dec_d;
    logic [K-2:0]         s_nxt;

    // Traceback walks backwards: the decision bit is the oldest input of the predecessor.
    assign dec_d    = surv_rdata[s_reg];
    assign s_nxt    = {s_reg[K-3:0], dec_d};
    assign oidx_nxt = oidx + 1'b1;
    assign busy     = !(state == WAIT_SYM && cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_SYM;
            cnt        <= '0;
            tb         <= '0;
            oidx       <= '0;
            s_reg      <= '0;
            bitbuf     <= '0;
            sym_ready  <= 1'b1;
            acs_start  <= 1'b0;
            acs_init   <= 1'b0;
            acs_sym    <= '0;
            acs_step   <= '0;
            surv_raddr <= '0;
            dec_bit    <= 1'b0;
            dec_valid  <= 1'b0;
            dec_last   <= 1'b0;
        end else begin
            unique case (state)
                WAIT_SYM: begin
                    if (sym_valid) begin
                        acs_sym   <= sym_in;
                        acs_step  <= cnt;
                        acs_init  <= (cnt == '0);
                        acs_start <= 1'b1;
                        sym_ready <= 1'b0;
                        state     <= ACS_RUN;
                    end
                end
                ACS_RUN: begin
                    // acs_done is not looked at during the start pulse itself
                    if (acs_start) begin
                        acs_start <= 1'b0;
                        acs_init  <= 1'b0;
                    end else if (acs_done) begin
                        if (cnt == LAST_STEP) begin
                            tb         <= LAST_STEP;
                            surv_raddr <= LAST_STEP;
                            s_reg      <= '0;
                            state      <= TB_ADDR;
                        end else begin
                            cnt       <= cnt + 1'b1;
                            sym_ready <= 1'b1;
                            state     <= WAIT_SYM;
                        end
                    end
                end
                TB_ADDR: begin
                    state <= TB_USE;
                end
                TB_USE: begin
                    bitbuf[tb] <= s_reg[K-2];
                    s_reg      <= s_nxt;
                    if (tb == '0) begin
                        // bitbuf[0] is being written this cycle, so present it directly
                        oidx      <= '0;
                        dec_bit   <= s_reg[K-2];
                        dec_last  <= (LAST_BIT == '0);
                        dec_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        tb         <= tb - 1'b1;
                        surv_raddr <= tb - 1'b1;
                        state      <= TB_ADDR;
                    end
                end
                OUT: begin
                    if (dec_ready) begin
                        if (oidx == LAST_BIT) begin
                            dec_valid <= 1'b0;
                            dec_last  <= 1'b0;
                            dec_bit   <= 1'b0;
                            cnt       <= '0;
                            sym_ready <= 1'b1;
                            state     <= WAIT_SYM;
                        end else begin
                            oidx     <= oidx_nxt;
                            dec_bit  <= bitbuf[oidx_nxt];
                            dec_last <= (oidx_nxt == LAST_BIT);
                        end
                    end
                end
                default: state <= WAIT_SYM;
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Scoreboard bench for viterbi_frame_ctrl: ACS responder, survivor-memory model and
// decoded-bit sink each check DUT activity against queues filled by the stimulus.
module tb_viterbi_frame_ctrl;

    localparam int K  = 3;
    localparam int FL = 15;
    localparam int NS = 4;
    localparam int SW = 4;
    localparam int ND = 13;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    sym_in = 2'b00;
    logic          sym_valid = 1'b0;
    logic          sym_ready;
    logic          acs_start, acs_init;
    logic [1:0]    acs_sym;
    logic [SW-1:0] acs_step;
    logic          resp_done = 1'b0;
    logic          spur_done = 1'b0;
    logic          acs_done;
    logic [SW-1:0] surv_raddr;
    logic [NS-1:0] surv_rdata = '0;
    logic          dec_bit, dec_valid, dec_last, busy;
    logic          dec_ready = 1'b1;

    assign acs_done = resp_done | spur_done;

    viterbi_frame_ctrl #(.K(K), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst_n(rst_n),
        .sym_in(sym_in), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .acs_start(acs_start), .acs_init(acs_init), .acs_sym(acs_sym), .acs_step(acs_step),
        .acs_done(acs_done),
        .surv_raddr(surv_raddr), .surv_rdata(surv_rdata),
        .dec_bit(dec_bit), .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_last(dec_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
        end
    endfunction

    // expected ACS requests {init, sym, step} and decoded bits {bit, last}
    logic [6:0] acs_q[$];
    logic [1:0] out_q[$];

    // survivor memory: 1-cycle registered read
    logic [NS-1:0] surv_mem [16];
    always @(posedge clk) surv_rdata <= surv_mem[surv_raddr];

    // ACS responder: checks each start, returns acs_done 3 cycles later, and times traceback
    int         done_wait = 0;
    int         tb_cyc = -1;
    logic [6:0] e;
    always @(negedge clk) begin
        if (!rst_n) begin
            resp_done = 1'b0;
            done_wait = 0;
            tb_cyc    = -1;
        end else begin
            if (tb_cyc >= 0) begin
                tb_cyc++;
                if (tb_cyc % 2 == 1 && tb_cyc < 2 * FL)
                    chk("surv_raddr", int'(surv_raddr), FL - 1 - (tb_cyc - 1) / 2);
                if (tb_cyc == 2 * FL) chk("dec_valid_during_tb", int'(dec_valid), 0);
                if (tb_cyc == 2 * FL + 1) begin
                    chk("dec_valid_after_tb", int'(dec_valid), 1);
                    tb_cyc = -1;
                end
            end
            if (resp_done) begin
                chk("sym_ready_after_done", int'(sym_ready), int'(acs_step != SW'(FL - 1)));
                resp_done = 1'b0;
            end
            if (acs_start) begin
                if (done_wait != 0 || acs_q.size() == 0) chk("acs_start_unexpected", 1, 0);
                else begin
                    e = acs_q.pop_front();
                    chk("acs_step", int'(acs_step), int'(e[3:0]));
                    chk("acs_init", int'(acs_init), int'(e[6]));
                    chk("acs_sym", int'(acs_sym), int'(e[5:4]));
                end
                done_wait = 3;
            end else if (done_wait > 0) begin
                done_wait--;
                if (done_wait == 0) begin
                    chk("sym_ready_low_in_acs", int'(sym_ready), 0);
                    resp_done = 1'b1;
                    if (acs_step == SW'(FL - 1)) tb_cyc = 0;
                end
            end
        end
    end

    // sink: pops expected bits on each transfer, optional 5-cycle stall at oidx 4
    int         stall_left = 0;
    int         frame_xfer = 0;
    int         total_xfer = 0;
    logic       bp_en = 1'b0;
    logic       bp_done = 1'b0;
    logic       held_bit, held_last;
    logic [1:0] o;
    always @(negedge clk) begin
        if (!rst_n) begin
            dec_ready  = 1'b1;
            stall_left = 0;
            frame_xfer = 0;
            bp_done    = 1'b0;
        end else begin
            if (stall_left > 0) begin
                dec_ready = 1'b0;
                chk("bp_valid_held", int'(dec_valid), 1);
                chk("bp_bit_held", int'(dec_bit), int'(held_bit));
                chk("bp_last_held", int'(dec_last), int'(held_last));
                stall_left--;
            end else if (bp_en && !bp_done && dec_valid && frame_xfer == 4) begin
                dec_ready = 1'b0;
                held_bit  = dec_bit;
                held_last = dec_last;
                stall_left = 4;
                bp_done   = 1'b1;
            end else begin
                dec_ready = 1'b1;
            end
            if (dec_valid && dec_ready) begin
                if (out_q.size() == 0) chk("dec_unexpected", 1, 0);
                else begin
                    o = out_q.pop_front();
                    chk("dec_bit", int'(dec_bit), int'(o[1]));
                    chk("dec_last", int'(dec_last), int'(o[0]));
                end
                total_xfer++;
                frame_xfer++;
                if (dec_last) begin
                    frame_xfer = 0;
                    bp_done    = 1'b0;
                end
            end
        end
    end

    function automatic logic [1:0] sym_of(input int i);
        return 2'((i * 3 + 1) % 4);
    endfunction

    task automatic push_bits(input logic [ND-1:0] u);
        for (int i = 0; i < ND; i++) out_q.push_back({u[i], (i == ND - 1)});
    endtask

    task automatic fill_mem(input logic [NS-1:0] v);
        for (int t = 0; t < 16; t++) surv_mem[t] = v;
    endtask

    // decisions for data u with zero tail: only the true path's state gets the right bit
    task automatic encode_mem(input logic [ND-1:0] u);
        logic [FL-1:0] uu;
        logic [K-2:0]  st;
        logic [NS-1:0] v;
        uu = {2'b00, u};
        fill_mem(4'b1010);
        for (int t = 2; t < FL; t++) begin
            st = {uu[t], uu[t-1]};
            v  = {NS{~uu[t-2]}};
            v[st] = uu[t-2];
            surv_mem[t] = v;
        end
    endtask

    task automatic send_sym(input int step, input logic spur);
        int t;
        logic [1:0] s;
        s = sym_of(step);
        t = 0;
        while (!sym_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("sym_ready_wait", int'(sym_ready), 1);
        if (spur) begin
            spur_done = 1'b1;
            @(negedge clk);
            spur_done = 1'b0;
            chk("spur_sym_ready", int'(sym_ready), 1);
            chk("spur_busy", int'(busy), 1);
            chk("spur_acs_start", int'(acs_start), 0);
        end
        sym_in    = s;
        sym_valid = 1'b1;
        acs_q.push_back({(step == 0), s, SW'(step)});
        @(negedge clk);
        sym_valid = 1'b0;
        chk("sym_ready_low_after_accept", int'(sym_ready), 0);
    endtask

    task automatic wait_frame_end(input int xfer0);
        int t;
        t = 0;
        while (!(sym_ready && !busy) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("frame_end_timeout", int'(t < 1000), 1);
        chk("xfers_per_frame", total_xfer - xfer0, ND);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0, t;
        fill_mem('0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sym_ready", int'(sym_ready), 1);
        chk("rst_acs_start", int'(acs_start), 0);
        chk("rst_dec_valid", int'(dec_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_surv_raddr", int'(surv_raddr), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // abort a frame with an asynchronous reset during step 7
        for (int i = 0; i < 8; i++) send_sym(i, 1'b0);
        chk("pre_rst_acs_step", int'(acs_step), 7);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sym_ready", int'(sym_ready), 1);
        chk("arst_acs_start", int'(acs_start), 0);
        chk("arst_acs_init", int'(acs_init), 0);
        chk("arst_acs_sym", int'(acs_sym), 0);
        chk("arst_acs_step", int'(acs_step), 0);
        chk("arst_dec_valid", int'(dec_valid), 0);
        chk("arst_dec_last", int'(dec_last), 0);
        chk("arst_dec_bit", int'(dec_bit), 0);
        chk("arst_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_sym_ready", int'(sym_ready), 1);
        chk("post_rst_busy", int'(busy), 0);

        // frame A: all-zero decisions, spurious acs_done in WAIT_SYM before step 3
        fill_mem('0);
        push_bits('0);
        x0 = total_xfer;
        for (int i = 0; i < FL; i++) send_sym(i, i == 3);
        wait_frame_end(x0);

        // frame B: all-one decisions with backpressure; next symbol offered during TB/OUT
        fill_mem('1);
        push_bits('1);
        bp_en = 1'b1;
        x0 = total_xfer;
        for (int i = 0; i < FL; i++) send_sym(i, 1'b0);
        sym_in    = sym_of(0);
        sym_valid = 1'b1;
        t = 0;
        while (!sym_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("held_sym_taken_after_frame", int'(sym_ready), 1);
        chk("xfers_before_held_sym", total_xfer - x0, ND);
        bp_en = 1'b0;

        // frame C: path-encoded decisions, symbol 0 is the one held above
        encode_mem(13'b1011001110100);
        push_bits(13'b1011001110100);
        acs_q.push_back({1'b1, sym_of(0), SW'(0)});
        x0 = total_xfer;
        @(negedge clk);
        sym_valid = 1'b0;
        chk("held_sym_accepted", int'(sym_ready), 0);
        for (int i = 1; i < FL; i++) send_sym(i, 1'b0);
        wait_frame_end(x0);

        chk("acs_q_drained", acs_q.size(), 0);
        chk("out_q_drained", out_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
